// File: rtl/key_gesture_pkg.sv
// Shared types and default timing constants for the key gesture decoder.
// Optional auto-repeat feature is selected by KEY_GESTURE_REPEAT_EN (see key_gesture.sv).
package key_gesture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HELD   = 3'd4
    } state_e;

    localparam int unsigned LONG_CYC_DEF = 25_000_000;
    localparam int unsigned DBL_CYC_DEF  = 12_500_000;
    localparam int unsigned RPT_CYC_DEF  = 5_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_gesture.sv
// Classifies debounced press/release pulses into short, double, long and repeat events.
// Define KEY_GESTURE_REPEAT_EN to enable periodic o_repeat pulses while a long press is held.
module key_gesture
    import key_gesture_pkg::*;
#(
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned DBL_CYC  = DBL_CYC_DEF,
    parameter int unsigned RPT_CYC  = RPT_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pos,
    input  logic i_neg,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CYC, DBL_CYC, RPT_CYC));

    if (LONG_CYC < 2 || DBL_CYC < 2 || RPT_CYC < 2) begin : g_bad_param
        $error("key_gesture: LONG_CYC, DBL_CYC and RPT_CYC must all be >= 2");
    end

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             busy_q, busy_d;
    logic             rpt_restart;

    // Simultaneous press and release cancel each other out.
    logic pos_ev, neg_ev;
    assign pos_ev = i_pos & ~i_neg;
    assign neg_ev = i_neg & ~i_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    // Input events are tested before timeouts so a release on the limit cycle wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pos_ev) state_d = ST_PRESS1;
            ST_PRESS1: begin
                if (neg_ev)                 state_d = ST_WAIT2;
                else if (cnt_q == LONG_LIM) state_d = ST_HELD;
            end
            ST_WAIT2: begin
                if (pos_ev)                state_d = ST_PRESS2;
                else if (cnt_q == DBL_LIM) state_d = ST_IDLE;
            end
            ST_PRESS2: if (neg_ev) state_d = ST_IDLE;
            ST_HELD:   if (neg_ev) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d != state_q || rpt_restart) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        short_d  = (state_q == ST_WAIT2)  && !pos_ev && (cnt_q == DBL_LIM);
        double_d = (state_q == ST_PRESS2) && neg_ev;
        long_d   = (state_q == ST_PRESS1) && !neg_ev && (cnt_q == LONG_LIM);
        busy_d   = (state_d != ST_IDLE);
`ifdef KEY_GESTURE_REPEAT_EN
        rpt_restart = (state_q == ST_HELD) && !neg_ev && (cnt_q == CNT_W'(RPT_CYC - 1));
`else
        rpt_restart = 1'b0;
`endif
        repeat_d = rpt_restart;
    end

    assign o_short  = short_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_key_gesture.sv
// Directed bench for key_gesture with LONG_CYC=20, DBL_CYC=8, RPT_CYC=5.
// Output vector order is {busy, short, double, long, repeat}; edge k=0 samples the first press.
module tb_key_gesture;

    localparam int unsigned LONG_CYC = 20;
    localparam int unsigned DBL_CYC  = 8;
    localparam int unsigned RPT_CYC  = 5;
`ifdef KEY_GESTURE_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_pos = 1'b0;
    logic i_neg = 1'b0;
    logic o_short, o_double, o_long, o_repeat, o_busy;
    logic [4:0] obs_w;

    int n_checks = 0;
    int n_fail   = 0;

    key_gesture #(
        .LONG_CYC(LONG_CYC),
        .DBL_CYC (DBL_CYC),
        .RPT_CYC (RPT_CYC)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_pos   (i_pos),
        .i_neg   (i_neg),
        .o_short (o_short),
        .o_double(o_double),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    assign obs_w = {o_busy, o_short, o_double, o_long, o_repeat};

    task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then look 1 time unit later.
    task automatic tick(input logic p, input logic n);
        i_pos = p;
        i_neg = n;
        @(posedge i_clk);
        #1;
        i_pos = 1'b0;
        i_neg = 1'b0;
    endtask

    initial begin
        logic [4:0] exp;

        repeat (3) @(posedge i_clk);
        #1;
        check_eq("reset_state", obs_w, 5'b00000);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Lone release and simultaneous press+release in IDLE are ignored.
        tick(1'b0, 1'b1);
        check_eq("idle_neg_ignored", obs_w, 5'b00000);
        tick(1'b1, 1'b1);
        check_eq("idle_both_ignored", obs_w, 5'b00000);
        tick(1'b0, 1'b0);
        check_eq("idle_both_after", obs_w, 5'b00000);

        // Single click: short pulse 8 edges after the release edge.
        for (int k = 0; k < 20; k++) begin
            tick(k == 0, k == 5);
            exp = {k < 13, k == 13, 1'b0, 1'b0, 1'b0};
            check_eq($sformatf("short k=%0d", k), obs_w, exp);
        end

        // Double click with a long second hold (also drives the counter into saturation).
        for (int k = 0; k < 46; k++) begin
            tick(k == 0 || k == 6, k == 3 || k == 40);
            exp = {k < 40, 1'b0, k == 40, 1'b0, 1'b0};
            check_eq($sformatf("double k=%0d", k), obs_w, exp);
        end

        // Long press held 40 cycles; repeats only when the feature is built in.
        for (int k = 0; k < 46; k++) begin
            tick(k == 0, k == 40);
            exp = {k < 40, 1'b0, 1'b0, k == 20,
                   RPT_ON && (k == 25 || k == 30 || k == 35)};
            check_eq($sformatf("long k=%0d", k), obs_w, exp);
        end

        // Release on the exact limit edge wins: WAIT2, then a short instead of a long.
        for (int k = 0; k < 32; k++) begin
            tick(k == 0, k == 20);
            exp = {k < 28, k == 28, 1'b0, 1'b0, 1'b0};
            check_eq($sformatf("race k=%0d", k), obs_w, exp);
        end

        // Asynchronous reset mid-gesture discards it.
        for (int k = 0; k < 4; k++) begin
            tick(k == 0, 1'b0);
            check_eq($sformatf("rst_pre k=%0d", k), obs_w, 5'b10000);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_async", obs_w, 5'b00000);
        tick(1'b0, 1'b1);
        check_eq("rst_held", obs_w, 5'b00000);
        tick(1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0);
            check_eq($sformatf("rst_post k=%0d", k), obs_w, 5'b00000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
